// File: rtl/dataflow_deadlock_monitor_pkg.sv
// Shared types and helpers for the dataflow deadlock monitor: walk FSM states,
// index/width helpers used by the stability filter and the wait-for-graph walker.
package dl_monitor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STABLE,
        CHASE,
        MARK,
        REPORT,
        EXHAUSTED
    } state_t;

    localparam int MAX_PROC = 64;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

    // Index of the least-significant set bit; 0 when the mask is empty.
    function automatic int lowest_set(input logic [MAX_PROC-1:0] mask);
        int idx;
        idx = 0;
        for (int i = MAX_PROC - 1; i >= 0; i--) begin
            if (mask[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/dataflow_deadlock_monitor_filter.sv
// Snapshot register and stability counter: flags any change of the blocked/wait_on
// inputs against last cycle and counts how long the FSM has seen them unchanged.
module dl_stability_filter
    import dl_monitor_pkg::*;
#(
    parameter int N_PROC        = 4,
    parameter int IDW           = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_PROC-1:0]     i_blocked,
    input  logic [N_PROC*IDW-1:0] i_wait_on,
    input  logic                  i_cnt_load,
    input  logic                  i_cnt_inc,
    output logic [N_PROC-1:0]     o_snap_blocked,
    output logic [N_PROC*IDW-1:0] o_snap_wait_on,
    output logic                  o_changed,
    output logic                  o_stable
);

    localparam int CNT_W  = clog2(STABLE_CYCLES + 1);
    localparam int SNAP_W = N_PROC * (IDW + 1);

    logic [SNAP_W-1:0] r_snap;
    logic [CNT_W-1:0]  r_cnt;
    logic [SNAP_W-1:0] w_live;

    assign w_live                           = {i_blocked, i_wait_on};
    assign o_changed                        = (w_live != r_snap);
    assign o_stable                         = (r_cnt == CNT_W'(STABLE_CYCLES));
    assign {o_snap_blocked, o_snap_wait_on} = r_snap;

    // Counter holds at STABLE_CYCLES; any cycle without load/inc clears it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_snap <= '0;
            r_cnt  <= '0;
        end else begin
            r_snap <= w_live;
            if (i_cnt_load) begin
                r_cnt <= CNT_W'(1);
            end else if (i_cnt_inc) begin
                if (!o_stable) r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/dataflow_deadlock_monitor.sv
// Runtime deadlock monitor: once the blocked/wait-on snapshot is stable, walks the
// wait-for graph one edge per cycle and latches a sticky report of the first cycle found.
module dataflow_deadlock_monitor
    import dl_monitor_pkg::*;
#(
    parameter int N_PROC        = 4,
    parameter int IDW           = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [N_PROC-1:0]     proc_blocked,
    input  logic [N_PROC*IDW-1:0] wait_on,
    input  logic                  clear,
    output logic                  busy,
    output logic                  deadlock_det,
    output logic [N_PROC-1:0]     deadlock_mask,
    output logic [IDW-1:0]        deadlock_origin,
    output logic [IDW:0]          cycle_len
);

    state_t              r_state, w_state_nxt;
    logic [IDW-1:0]      r_cur, w_cur_nxt;
    logic [IDW-1:0]      r_start, w_start_nxt;
    logic [IDW-1:0]      r_origin, w_origin_nxt;
    logic [N_PROC-1:0]   r_visited, w_visited_nxt;
    logic [N_PROC-1:0]   r_tried, w_tried_nxt;
    logic [N_PROC-1:0]   r_mask, w_mask_nxt;
    logic [IDW:0]        r_len, w_len_nxt;
    logic                r_det, w_det_nxt;
    logic [N_PROC-1:0]   r_dmask, w_dmask_nxt;
    logic [IDW-1:0]      r_dorigin, w_dorigin_nxt;
    logic [IDW:0]        r_dlen, w_dlen_nxt;

    logic                  w_cnt_load, w_cnt_inc, w_changed, w_stable;
    logic [N_PROC-1:0]     w_snap_blocked;
    logic [N_PROC*IDW-1:0] w_snap_wait;
    logic [IDW-1:0]        w_nxt;
    logic                  w_cur_blocked, w_edge_valid;
    logic [N_PROC-1:0]     w_nxt_oh, w_start_oh;
    logic [N_PROC-1:0]     w_cand0, w_cand1, w_first0_oh, w_first1_oh;
    logic [IDW-1:0]        w_first0, w_first1;

    dl_stability_filter #(
        .N_PROC        (N_PROC),
        .IDW           (IDW),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clock          (clock),
        .reset          (reset),
        .i_blocked      (proc_blocked),
        .i_wait_on      (wait_on),
        .i_cnt_load     (w_cnt_load),
        .i_cnt_inc      (w_cnt_inc),
        .o_snap_blocked (w_snap_blocked),
        .o_snap_wait_on (w_snap_wait),
        .o_changed      (w_changed),
        .o_stable       (w_stable)
    );

    // The walk reads the registered snapshot; any input change aborts it the same cycle.
    always_comb begin
        w_nxt         = '0;
        w_cur_blocked = 1'b0;
        w_start_oh    = '0;
        for (int i = 0; i < N_PROC; i++) begin
            if (int'(r_cur) == i) begin
                w_nxt         = w_snap_wait[i*IDW +: IDW];
                w_cur_blocked = w_snap_blocked[i];
            end
            if (int'(r_start) == i) w_start_oh[i] = 1'b1;
        end
    end

    always_comb begin
        w_nxt_oh = '0;
        for (int i = 0; i < N_PROC; i++) begin
            if (int'(w_nxt) == i) w_nxt_oh[i] = 1'b1;
        end
    end

    // An out-of-range wait_on index decodes to an empty one-hot: no edge.
    assign w_edge_valid = |w_nxt_oh;
    assign w_cand0      = w_snap_blocked & ~r_tried;
    assign w_cand1      = w_snap_blocked & ~(r_tried | w_start_oh);
    assign w_first0_oh  = w_cand0 & (~w_cand0 + N_PROC'(1));
    assign w_first1_oh  = w_cand1 & (~w_cand1 + N_PROC'(1));
    assign w_first0     = IDW'(lowest_set(MAX_PROC'(w_cand0)));
    assign w_first1     = IDW'(lowest_set(MAX_PROC'(w_cand1)));

    always_comb begin
        w_state_nxt   = r_state;
        w_cur_nxt     = r_cur;
        w_start_nxt   = r_start;
        w_origin_nxt  = r_origin;
        w_visited_nxt = r_visited;
        w_tried_nxt   = r_tried;
        w_mask_nxt    = r_mask;
        w_len_nxt     = r_len;
        w_det_nxt     = r_det;
        w_dmask_nxt   = r_dmask;
        w_dorigin_nxt = r_dorigin;
        w_dlen_nxt    = r_dlen;
        w_cnt_load    = 1'b0;
        w_cnt_inc     = 1'b0;
        if (clear) begin
            w_state_nxt   = IDLE;
            w_cur_nxt     = '0;
            w_start_nxt   = '0;
            w_origin_nxt  = '0;
            w_visited_nxt = '0;
            w_tried_nxt   = '0;
            w_mask_nxt    = '0;
            w_len_nxt     = '0;
            w_det_nxt     = 1'b0;
            w_dmask_nxt   = '0;
            w_dorigin_nxt = '0;
            w_dlen_nxt    = '0;
        end else if (!enable) begin
            w_state_nxt   = IDLE;
            w_visited_nxt = '0;
            w_tried_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|proc_blocked) begin
                        w_state_nxt = STABLE;
                        w_cnt_load  = 1'b1;
                    end
                end
                STABLE: begin
                    if (w_changed || !(|proc_blocked)) begin
                        w_state_nxt   = IDLE;
                        w_visited_nxt = '0;
                        w_tried_nxt   = '0;
                    end else if (w_stable) begin
                        w_state_nxt   = CHASE;
                        w_start_nxt   = w_first0;
                        w_cur_nxt     = w_first0;
                        w_visited_nxt = w_first0_oh;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                CHASE: begin
                    if (w_changed) begin
                        w_state_nxt   = IDLE;
                        w_visited_nxt = '0;
                        w_tried_nxt   = '0;
                    end else if (!w_cur_blocked || !w_edge_valid) begin
                        w_tried_nxt = r_tried | w_start_oh;
                        if (|w_cand1) begin
                            w_start_nxt   = w_first1;
                            w_cur_nxt     = w_first1;
                            w_visited_nxt = w_first1_oh;
                        end else begin
                            w_state_nxt = EXHAUSTED;
                        end
                    end else if (|(r_visited & w_nxt_oh)) begin
                        w_state_nxt  = MARK;
                        w_origin_nxt = w_nxt;
                        w_cur_nxt    = w_nxt;
                        w_mask_nxt   = w_nxt_oh;
                        w_len_nxt    = (IDW+1)'(1);
                    end else begin
                        w_visited_nxt = r_visited | w_nxt_oh;
                        w_cur_nxt     = w_nxt;
                    end
                end
                MARK: begin
                    if (w_changed) begin
                        w_state_nxt   = IDLE;
                        w_visited_nxt = '0;
                        w_tried_nxt   = '0;
                    end else if (w_nxt == r_origin) begin
                        w_state_nxt   = REPORT;
                        w_det_nxt     = 1'b1;
                        w_dmask_nxt   = r_mask;
                        w_dorigin_nxt = r_origin;
                        w_dlen_nxt    = r_len;
                    end else begin
                        w_mask_nxt = r_mask | w_nxt_oh;
                        w_len_nxt  = r_len + (IDW+1)'(1);
                        w_cur_nxt  = w_nxt;
                    end
                end
                REPORT: begin
                    w_state_nxt = REPORT;
                end
                EXHAUSTED: begin
                    if (w_changed) begin
                        w_state_nxt   = IDLE;
                        w_visited_nxt = '0;
                        w_tried_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cur     <= '0;
            r_start   <= '0;
            r_origin  <= '0;
            r_visited <= '0;
            r_tried   <= '0;
            r_mask    <= '0;
            r_len     <= '0;
            r_det     <= 1'b0;
            r_dmask   <= '0;
            r_dorigin <= '0;
            r_dlen    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur     <= w_cur_nxt;
            r_start   <= w_start_nxt;
            r_origin  <= w_origin_nxt;
            r_visited <= w_visited_nxt;
            r_tried   <= w_tried_nxt;
            r_mask    <= w_mask_nxt;
            r_len     <= w_len_nxt;
            r_det     <= w_det_nxt;
            r_dmask   <= w_dmask_nxt;
            r_dorigin <= w_dorigin_nxt;
            r_dlen    <= w_dlen_nxt;
        end
    end

    assign busy            = (r_state == STABLE) || (r_state == CHASE) || (r_state == MARK);
    assign deadlock_det    = r_det;
    assign deadlock_mask   = r_dmask;
    assign deadlock_origin = r_dorigin;
    assign cycle_len       = r_dlen;

endmodule

// File: tb/tb_dataflow_deadlock_monitor.sv
// Scenario bench for the deadlock monitor: directed cases on 2-, 3- and 4-process
// instances plus randomized wait graphs checked against a path-following reference.
module tb_dataflow_deadlock_monitor;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // 4-process instance
    logic       en4 = 1'b1, clr4 = 1'b0;
    logic [3:0] blk4 = '0;
    logic [7:0] wo4 = '0;
    logic       busy4, det4;
    logic [3:0] mask4;
    logic [1:0] org4;
    logic [2:0] len4;

    // 2-process instance
    logic       en2 = 1'b1, clr2 = 1'b0;
    logic [1:0] blk2 = '0;
    logic [1:0] wo2 = '0;
    logic       busy2, det2;
    logic [1:0] mask2;
    logic [0:0] org2;
    logic [1:0] len2;

    // 3-process instance
    logic       en3 = 1'b1, clr3 = 1'b0;
    logic [2:0] blk3 = '0;
    logic [5:0] wo3 = '0;
    logic       busy3, det3;
    logic [2:0] mask3;
    logic [1:0] org3;
    logic [2:0] len3;

    dataflow_deadlock_monitor #(.N_PROC(4), .IDW(2), .STABLE_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .enable(en4), .proc_blocked(blk4), .wait_on(wo4),
        .clear(clr4), .busy(busy4), .deadlock_det(det4), .deadlock_mask(mask4),
        .deadlock_origin(org4), .cycle_len(len4));

    dataflow_deadlock_monitor #(.N_PROC(2), .IDW(1), .STABLE_CYCLES(4)) dut2 (
        .clock(clock), .reset(reset), .enable(en2), .proc_blocked(blk2), .wait_on(wo2),
        .clear(clr2), .busy(busy2), .deadlock_det(det2), .deadlock_mask(mask2),
        .deadlock_origin(org2), .cycle_len(len2));

    dataflow_deadlock_monitor #(.N_PROC(3), .IDW(2), .STABLE_CYCLES(4)) dut3 (
        .clock(clock), .reset(reset), .enable(en3), .proc_blocked(blk3), .wait_on(wo3),
        .clear(clr3), .busy(busy3), .deadlock_det(det3), .deadlock_mask(mask3),
        .deadlock_origin(org3), .cycle_len(len3));

    task automatic ticks(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Leaves the 4-process instance in IDLE; returns on a negedge so the caller
    // can apply new inputs that the next rising edge samples as "edge 1".
    task automatic do_clear();
        clr4 = 1'b1;
        @(negedge clock);
        clr4 = 1'b0;
    endtask

    // Follow wait edges from each blocked process in ascending order; the first
    // walk that revisits a node yields the cycle (entry node, members, length).
    task automatic ref_walk(input logic [3:0] b, input logic [7:0] w, output logic det,
                            output logic [3:0] m, output logic [1:0] o, output logic [2:0] l);
        int first_seen [4];
        int order [5];
        int node;
        det = 1'b0; m = '0; o = '0; l = '0;
        for (int s = 0; s < 4; s++) begin
            if (det || !b[s]) continue;
            foreach (first_seen[k]) first_seen[k] = -1;
            node = s;
            for (int step = 0; step <= 4; step++) begin
                if (first_seen[node] >= 0) begin
                    det = 1'b1;
                    o   = 2'(node);
                    l   = 3'(step - first_seen[node]);
                    for (int k = first_seen[node]; k < step; k++) m[order[k]] = 1'b1;
                    break;
                end
                if (!b[node]) break;
                first_seen[node] = step;
                order[step] = node;
                node = int'(w[node*2 +: 2]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ticks(2);
        n_cmp++; if (det4 !== 1'b0) begin n_err++; $display("FAIL reset_det: got %0d want 0", det4); end
        n_cmp++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0d want 0", busy4); end
        n_cmp++; if (mask4 !== 4'b0) begin n_err++; $display("FAIL reset_mask: got %b want 0000", mask4); end
        n_cmp++; if (org4 !== 2'd0) begin n_err++; $display("FAIL reset_origin: got %0d want 0", org4); end
        n_cmp++; if (len4 !== 3'd0) begin n_err++; $display("FAIL reset_len: got %0d want 0", len4); end
        reset = 1'b1;
        ticks(1);
        n_cmp++; if (det4 !== 1'b0 || busy4 !== 1'b0) begin n_err++; $display("FAIL reset_release: got det=%0d busy=%0d want 0/0", det4, busy4); end
    endtask

    task automatic test_mutual_wait();
        blk2 = 2'b11;
        wo2  = 2'b01;
        ticks(8);
        n_cmp++; if (det2 !== 1'b0) begin n_err++; $display("FAIL mutual_early: got det=%0d want 0 at cycle 8", det2); end
        ticks(1);
        n_cmp++; if (det2 !== 1'b1) begin n_err++; $display("FAIL mutual_det: got %0d want 1 at cycle 9", det2); end
        n_cmp++; if (mask2 !== 2'b11) begin n_err++; $display("FAIL mutual_mask: got %b want 11", mask2); end
        n_cmp++; if (org2 !== 1'b0) begin n_err++; $display("FAIL mutual_origin: got %0d want 0", org2); end
        n_cmp++; if (len2 !== 2'd2) begin n_err++; $display("FAIL mutual_len: got %0d want 2", len2); end
    endtask

    task automatic test_out_of_range();
        blk3 = 3'b001;
        wo3  = 6'b00_00_11;
        ticks(3);
        n_cmp++; if (busy3 !== 1'b1) begin n_err++; $display("FAIL oor_busy: got %0d want 1", busy3); end
        ticks(27);
        n_cmp++; if (det3 !== 1'b0) begin n_err++; $display("FAIL oor_det: got %0d want 0", det3); end
        n_cmp++; if (busy3 !== 1'b0) begin n_err++; $display("FAIL oor_idle: got busy=%0d want 0", busy3); end
    endtask

    task automatic test_chain();
        do_clear();
        blk4 = 4'b0111;
        wo4  = {2'd0, 2'd3, 2'd2, 2'd1};
        ticks(3);
        n_cmp++; if (busy4 !== 1'b1) begin n_err++; $display("FAIL chain_busy_on: got %0d want 1", busy4); end
        ticks(13);
        n_cmp++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL chain_busy_off: got %0d want 0 by cycle 16", busy4); end
        n_cmp++; if (det4 !== 1'b0) begin n_err++; $display("FAIL chain_det: got %0d want 0", det4); end
    endtask

    task automatic test_tail();
        do_clear();
        blk4 = 4'b1111;
        wo4  = {2'd2, 2'd3, 2'd2, 2'd1};
        ticks(40);
        n_cmp++; if (det4 !== 1'b1) begin n_err++; $display("FAIL tail_det: got %0d want 1", det4); end
        n_cmp++; if (org4 !== 2'd2) begin n_err++; $display("FAIL tail_origin: got %0d want 2", org4); end
        n_cmp++; if (mask4 !== 4'b1100) begin n_err++; $display("FAIL tail_mask: got %b want 1100", mask4); end
        n_cmp++; if (len4 !== 3'd2) begin n_err++; $display("FAIL tail_len: got %0d want 2", len4); end
    endtask

    task automatic test_self_loop_abort();
        do_clear();
        blk4 = 4'b0010;
        wo4  = {2'd0, 2'd0, 2'd1, 2'd0};
        ticks(2);
        blk4 = 4'b0000;
        ticks(1);
        blk4 = 4'b0010;
        ticks(6);
        n_cmp++; if (det4 !== 1'b0) begin n_err++; $display("FAIL self_abort: got det=%0d want 0", det4); end
        ticks(1);
        n_cmp++; if (det4 !== 1'b1) begin n_err++; $display("FAIL self_det: got %0d want 1", det4); end
        n_cmp++; if (mask4 !== 4'b0010) begin n_err++; $display("FAIL self_mask: got %b want 0010", mask4); end
        n_cmp++; if (len4 !== 3'd1) begin n_err++; $display("FAIL self_len: got %0d want 1", len4); end
        n_cmp++; if (org4 !== 2'd1) begin n_err++; $display("FAIL self_origin: got %0d want 1", org4); end
    endtask

    task automatic test_clear_collision();
        do_clear();
        blk4 = 4'b0011;
        wo4  = {2'd0, 2'd0, 2'd0, 2'd1};
        ticks(8);
        clr4 = 1'b1;
        ticks(1);
        clr4 = 1'b0;
        n_cmp++; if (det4 !== 1'b0 || mask4 !== 4'b0) begin n_err++; $display("FAIL clear_wins: got det=%0d mask=%b want 0/0000", det4, mask4); end
        ticks(8);
        n_cmp++; if (det4 !== 1'b0) begin n_err++; $display("FAIL clear_fresh_wait: got det=%0d want 0", det4); end
        ticks(1);
        n_cmp++; if (det4 !== 1'b1 || mask4 !== 4'b0011) begin n_err++; $display("FAIL clear_redetect: got det=%0d mask=%b want 1/0011", det4, mask4); end
        clr4 = 1'b1;
        ticks(1);
        clr4 = 1'b0;
        n_cmp++; if ({det4, mask4, org4, len4} !== 10'b0) begin n_err++; $display("FAIL clear_drop: got det=%0d mask=%b org=%0d len=%0d want all 0", det4, mask4, org4, len4); end
    endtask

    task automatic test_enable();
        do_clear();
        en4  = 1'b0;
        blk4 = 4'b1111;
        wo4  = {2'd3, 2'd2, 2'd1, 2'd0};
        ticks(20);
        n_cmp++; if (det4 !== 1'b0 || busy4 !== 1'b0) begin n_err++; $display("FAIL en_off: got det=%0d busy=%0d want 0/0", det4, busy4); end
        en4 = 1'b1;
        ticks(15);
        n_cmp++; if (det4 !== 1'b1 || mask4 !== 4'b0001 || len4 !== 3'd1) begin n_err++; $display("FAIL en_on: got det=%0d mask=%b len=%0d want 1/0001/1", det4, mask4, len4); end
        en4 = 1'b0;
        ticks(3);
        n_cmp++; if (det4 !== 1'b1 || mask4 !== 4'b0001) begin n_err++; $display("FAIL en_sticky: got det=%0d mask=%b want 1/0001", det4, mask4); end
        en4 = 1'b1;
    endtask

    task automatic test_random();
        logic       e_det;
        logic [3:0] e_mask;
        logic [1:0] e_org;
        logic [2:0] e_len;
        for (int it = 0; it < 30; it++) begin
            do_clear();
            blk4 = 4'($urandom_range(0, 15));
            wo4  = 8'($urandom);
            ref_walk(blk4, wo4, e_det, e_mask, e_org, e_len);
            ticks(40);
            n_cmp++;
            if (det4 !== e_det || mask4 !== e_mask || org4 !== e_org || len4 !== e_len || busy4 !== 1'b0) begin
                n_err++;
                $display("FAIL random[%0d] blk=%b wo=%h: got det=%0d mask=%b org=%0d len=%0d busy=%0d want %0d/%b/%0d/%0d/0",
                         it, blk4, wo4, det4, mask4, org4, len4, busy4, e_det, e_mask, e_org, e_len);
            end
        end
    endtask

    task automatic test_reset_mid_chase();
        do_clear();
        blk4 = 4'b0011;
        wo4  = {2'd0, 2'd0, 2'd0, 2'd1};
        ticks(6);
        n_cmp++; if (busy4 !== 1'b1) begin n_err++; $display("FAIL midchase_busy: got %0d want 1", busy4); end
        reset = 1'b0;
        #1;
        n_cmp++; if (busy4 !== 1'b0 || det4 !== 1'b0) begin n_err++; $display("FAIL midchase_reset: got busy=%0d det=%0d want 0/0", busy4, det4); end
        ticks(2);
        reset = 1'b1;
        ticks(3);
        n_cmp++; if (det4 !== 1'b0 || mask4 !== 4'b0) begin n_err++; $display("FAIL reset_no_spurious: got det=%0d mask=%b want 0/0000", det4, mask4); end
    endtask

    initial begin
        test_reset();
        test_mutual_wait();
        test_out_of_range();
        test_chain();
        test_tail();
        test_self_loop_abort();
        test_clear_collision();
        test_enable();
        test_random();
        test_reset_mid_chase();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
